big_and_seq: RTL and testbench

- Stimulus sequencer and self-checker for the N-input `big_and` power-trace datapath.
- After a start pulse, drives the AND inputs through a programmed vector pattern, holding each vector for a fixed number of cycles.
- Samples the AND output for each vector and compares it against the expected AND-reduction.
- Then holds the last vector quiet for a tail window, so the trace ends with a defined idle period.
- Sits between the testbench/top and the `big_and` instance; it replaces hand-written `#delay` stimulus in generated traces.

---
 rtl/big_and_seq_pkg.sv | 23 ++
 rtl/big_and_seq_vec_gen.sv | 33 +++
 rtl/big_and_seq.sv | 158 +++++++++++++++
 tb/tb_big_and_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/big_and_seq_pkg.sv
// Shared types and helpers for the big_and stimulus sequencer.
package big_and_seq_pkg;

    typedef enum logic [1:0] {
        THERM = 2'd0,
        WALK  = 2'd1,
        BIN   = 2'd2,
        RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        TAIL  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Number of vectors a run applies; the reserved mode behaves as thermometer.
    function automatic int unsigned steps_for_mode(input mode_e mode, input int unsigned n_in);
        return (mode == BIN) ? (32'd1 << n_in) : (n_in + 32'd1);
    endfunction

endpackage

// File: rtl/big_and_seq_vec_gen.sv
// Maps (pattern, step index) to the AND input vector and its expected AND-reduction.
module big_and_vec_gen
    import big_and_seq_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned CNT_W = N_IN + 1
) (
    input  mode_e             mode,
    input  logic [CNT_W-1:0]  step,
    output logic [N_IN-1:0]   vec_c,
    output logic              exp_c
);

    always_comb begin
        vec_c = '0;
        case (mode)
            WALK: begin
                for (int i = 0; i < int'(N_IN); i++) begin
                    vec_c[i] = (step == CNT_W'(i + 1));
                end
            end
            BIN: vec_c = N_IN'(step);
            default: begin
                for (int i = 0; i < int'(N_IN); i++) begin
                    vec_c[i] = (CNT_W'(i) < step);
                end
            end
        endcase
    end

    assign exp_c = &vec_c;

endmodule

// File: rtl/big_and_seq.sv
// Sequencer that walks the big_and inputs through a pattern, checks each sample and ends with a quiet tail.
module big_and_seq
    import big_and_seq_pkg::*;
#(
    parameter int unsigned N_IN        = 4,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned TAIL_CYCLES = 10,
    parameter int unsigned CNT_W       = N_IN + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic              out_i,
    output logic [N_IN-1:0]   in_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  step_o,
    output logic [CNT_W-1:0]  ones_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    localparam int unsigned HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned TAIL_W    = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;
    localparam int unsigned HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam int unsigned TAIL_LAST = (TAIL_CYCLES > 0) ? TAIL_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // The binary pattern has 2^N_IN steps, so the counters need at least N_IN+1 bits.
    if (CNT_W <= N_IN) begin : g_cnt_w_check
        $error("big_and_seq: CNT_W must exceed N_IN to count the binary pattern");
    end

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d, mode_sel;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [TAIL_W-1:0]   tail_q, tail_d;
    logic                exp_q, exp_d;
    logic [N_IN-1:0]     in_d;
    logic                busy_d, done_d;
    logic [CNT_W-1:0]    step_d, ones_d, err_d;
    logic [CNT_W-1:0]    idx_nxt, step_last;
    logic [N_IN-1:0]     vec_nxt;
    logic                exp_nxt;

    // Generator always looks one vector ahead: vector 0 in IDLE, vector k+1 while applying k.
    assign mode_sel  = (state_q == IDLE) ? mode_e'(mode_i) : mode_q;
    assign idx_nxt   = (state_q == IDLE) ? '0 : CNT_W'(step_o + CNT_W'(1));
    assign step_last = CNT_W'(steps_for_mode(mode_q, N_IN) - 32'd1);

    big_and_vec_gen #(
        .N_IN  (N_IN),
        .CNT_W (CNT_W)
    ) u_vec_gen (
        .mode  (mode_sel),
        .step  (idx_nxt),
        .vec_c (vec_nxt),
        .exp_c (exp_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        hold_d  = hold_q;
        tail_d  = tail_q;
        exp_d   = exp_q;
        in_d    = in_o;
        step_d  = step_o;
        busy_d  = busy_o;
        done_d  = 1'b0;
        ones_d  = ones_cnt_o;
        err_d   = err_cnt_o;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = APPLY;
                    mode_d  = mode_sel;
                    hold_d  = '0;
                    tail_d  = '0;
                    in_d    = vec_nxt;
                    exp_d   = exp_nxt;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    ones_d  = '0;
                    err_d   = '0;
                end
            end
            APPLY: begin
                if (hold_q == HOLD_W'(HOLD_LAST)) begin
                    hold_d = '0;
                    ones_d = CNT_W'(ones_cnt_o + CNT_W'(out_i));
                    if ((out_i != exp_q) && (err_cnt_o != CNT_MAX)) begin
                        err_d = CNT_W'(err_cnt_o + CNT_W'(1));
                    end
                    if (step_o != step_last) begin
                        step_d = idx_nxt;
                        in_d   = vec_nxt;
                        exp_d  = exp_nxt;
                    end else if (TAIL_CYCLES == 0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = TAIL;
                    end
                end else begin
                    hold_d = HOLD_W'(hold_q + HOLD_W'(1));
                end
            end
            TAIL: begin
                if (tail_q == TAIL_W'(TAIL_LAST)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    tail_d = TAIL_W'(tail_q + TAIL_W'(1));
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= THERM;
            hold_q     <= '0;
            tail_q     <= '0;
            exp_q      <= 1'b0;
            in_o       <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            step_o     <= '0;
            ones_cnt_o <= '0;
            err_cnt_o  <= '0;
        end else begin
            mode_q     <= mode_d;
            hold_q     <= hold_d;
            tail_q     <= tail_d;
            exp_q      <= exp_d;
            in_o       <= in_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            step_o     <= step_d;
            ones_cnt_o <= ones_d;
            err_cnt_o  <= err_d;
        end
    end

endmodule

// File: tb/tb_big_and_seq.sv
// Scoreboard bench for big_and_seq: two instances (hold 1 and hold 3) share start/mode and a modelled big_and.
module tb_big_and_seq;

    localparam int unsigned N      = 4;
    localparam int unsigned CW     = N + 1;
    localparam int unsigned TAIL_N = 10;
    localparam int          LIMIT  = 400;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start     = 1'b0;
    logic [1:0] mode      = 2'd0;
    logic       force_en  = 1'b0;
    logic       force_val = 1'b0;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    event       launch;
    event       flush;
    logic [1:0] run_mode;
    logic       run_fe;
    logic       run_fv;
    int         accept_cyc;

    typedef struct { logic [N-1:0] vec; int step; } beat_t;
    typedef struct { int ones; int errs; int cycles; int start; } res_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void check(input string name, input int g, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, g, act, exp, $time);
        end
    endfunction

    function automatic int model_steps(input logic [1:0] m);
        return (m == 2'd2) ? (1 << N) : int'(N) + 1;
    endfunction

    // Pattern vectors straight from their arithmetic definitions.
    function automatic logic [N-1:0] model_vec(input logic [1:0] m, input int k);
        case (m)
            2'd1:    return (k == 0) ? '0 : N'(1 << (k - 1));
            2'd2:    return N'(k);
            default: return N'((1 << k) - 1);
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int unsigned H = (g == 0) ? 1 : 3;

        logic [N-1:0]  in_vec;
        logic          busy, done, out;
        logic [CW-1:0] step, ones, errs;
        beat_t         beat_q[$];
        res_t          res_q[$];
        int            busy_cycles = 0;
        int            done_cnt    = 0;
        logic [N-1:0]  last_vec    = '0;

        assign out = force_en ? force_val : &in_vec;

        big_and_seq #(
            .N_IN        (N),
            .HOLD_CYCLES (H),
            .TAIL_CYCLES (TAIL_N),
            .CNT_W       (CW)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start_i    (start),
            .mode_i     (mode),
            .out_i      (out),
            .in_o       (in_vec),
            .busy_o     (busy),
            .done_o     (done),
            .step_o     (step),
            .ones_cnt_o (ones),
            .err_cnt_o  (errs)
        );

        // Expected per-cycle beats and end-of-run result for an accepted start.
        always @(launch) begin
            int           s, o;
            logic [N-1:0] v;
            res_t         r;
            s = model_steps(run_mode);
            r.ones = 0; r.errs = 0;
            v = '0;
            for (int k = 0; k < s; k++) begin
                v = model_vec(run_mode, k);
                for (int h = 0; h < int'(H); h++) beat_q.push_back('{v, k});
                o = run_fe ? int'(run_fv) : int'(&v);
                r.ones += o;
                if ((o != int'(&v)) && (r.errs < (1 << CW) - 1)) r.errs++;
            end
            for (int t = 0; t < int'(TAIL_N); t++) beat_q.push_back('{v, s - 1});
            r.cycles = s * int'(H) + int'(TAIL_N);
            r.start  = accept_cyc;
            res_q.push_back(r);
        end

        always @(flush) begin
            beat_q.delete();
            res_q.delete();
        end

        always @(negedge clk) begin
            beat_t b;
            res_t  r;
            if (!rst_n) begin
                busy_cycles = 0;
                last_vec    = '0;
            end else begin
                if (busy) begin
                    busy_cycles++;
                    if (beat_q.size() == 0) begin
                        check("unexpected_busy", g, 1, 0);
                    end else begin
                        b = beat_q.pop_front();
                        check("in_o", g, in_vec, b.vec);
                        check("step_o", g, step, b.step);
                        last_vec = b.vec;
                    end
                end else if (!done) begin
                    check("idle_hold_in_o", g, in_vec, last_vec);
                end
                if (done) begin
                    if (res_q.size() == 0) begin
                        check("unexpected_done", g, 1, 0);
                    end else begin
                        r = res_q.pop_front();
                        check("ones_cnt", g, ones, r.ones);
                        check("err_cnt", g, errs, r.errs);
                        check("done_latency", g, cyc - r.start, r.cycles);
                        check("busy_cycles", g, busy_cycles, r.cycles);
                        check("busy_in_done", g, busy, 0);
                        check("beats_left", g, beat_q.size(), 0);
                    end
                    busy_cycles = 0;
                    done_cnt++;
                end
            end
        end
    end

    function automatic void check_zero(input string tag, input int g, input logic [N-1:0] v,
                                       input logic b, input logic d, input logic [CW-1:0] s,
                                       input logic [CW-1:0] o, input logic [CW-1:0] e);
        check({tag, "_in_o"}, g, v, 0);
        check({tag, "_busy"}, g, b, 0);
        check({tag, "_done"}, g, d, 0);
        check({tag, "_step"}, g, s, 0);
        check({tag, "_ones"}, g, o, 0);
        check({tag, "_err"}, g, e, 0);
    endfunction

    task automatic zero_both(input string tag);
        check_zero(tag, 0, g_cfg[0].in_vec, g_cfg[0].busy, g_cfg[0].done,
                   g_cfg[0].step, g_cfg[0].ones, g_cfg[0].errs);
        check_zero(tag, 1, g_cfg[1].in_vec, g_cfg[1].busy, g_cfg[1].done,
                   g_cfg[1].step, g_cfg[1].ones, g_cfg[1].errs);
    endtask

    task automatic accept(input logic [1:0] m, input logic fe, input logic fv);
        force_en  = fe;
        force_val = fv;
        mode      = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        run_mode   = m;
        run_fe     = fe;
        run_fv     = fv;
        accept_cyc = cyc;
        -> launch;
        mode = 2'($urandom);
    endtask

    task automatic run(input logic [1:0] m, input logic fe, input logic fv, input bit poke);
        int d0, d1, n;
        d0 = g_cfg[0].done_cnt;
        d1 = g_cfg[1].done_cnt;
        accept(m, fe, fv);
        if (poke) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            mode  = 2'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (((g_cfg[0].done_cnt == d0) || (g_cfg[1].done_cnt == d1)) && (n < LIMIT)) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", 0, int'(n < LIMIT), 1);
    endtask

    initial begin
        int sel;
        repeat (2) @(negedge clk);
        zero_both("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(2'd0, 1'b0, 1'b0, 1'b1);   // thermometer, ignored mid-run start
        run(2'd2, 1'b0, 1'b0, 1'b0);   // binary
        run(2'd1, 1'b1, 1'b1, 1'b0);   // walking-one, out stuck at 1
        run(2'd0, 1'b1, 1'b0, 1'b0);   // thermometer, out stuck at 0
        run(2'd3, 1'b0, 1'b0, 1'b0);   // reserved behaves as thermometer
        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(0, 2));
            run(2'($urandom_range(0, 3)), logic'(sel != 0), logic'(sel == 2), bit'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a run.
        accept(2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        zero_both("async_reset");
        -> flush;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(2'd0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
